// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target transmit path.
//   tx_state_t     - transmit sequencer state encoding
//   ACK / NACK     - SDA level the master drives in the acknowledge slot
//   DATA_WIDTH_DEF - default bits per transmitted byte
package i2c_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic ACK            = 1'b0;
  localparam logic NACK           = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_WAIT_RISE,
    ST_BIT_WAIT_FALL,
    ST_ACK_WAIT_RISE,
    ST_ACK_WAIT_FALL
  } tx_state_t;

endpackage

// File: rtl/i2c_tx_sequencer_if.sv
// i2c_tx_sequencer_if: bus bundle between the SCL/SDA edge detector, the TX
// FIFO and the transmit sequencer.
//   slave  modport - the sequencer: consumes edge pulses, SDA level, FIFO head;
//                    produces SDA drive, FIFO pop and status pulses.
//   master modport - the environment driving the sequencer.
interface i2c_tx_sequencer_if #(
  parameter int DATA_WIDTH = i2c_pkg::DATA_WIDTH_DEF
);
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;
  logic                  sda_in;
  logic                  tx_enable;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  tx_data_ack;
  logic                  sda_out;
  logic                  byte_sent;
  logic                  ack_received;
  logic                  nack_received;
  logic                  tx_underrun;
  logic                  busy;

  modport slave (
    input  scl_rise, scl_fall, start_det, stop_det, sda_in, tx_enable,
           tx_data, tx_data_valid,
    output tx_data_ack, sda_out, byte_sent, ack_received, nack_received,
           tx_underrun, busy
  );

  modport master (
    output scl_rise, scl_fall, start_det, stop_det, sda_in, tx_enable,
           tx_data, tx_data_valid,
    input  tx_data_ack, sda_out, byte_sent, ack_received, nack_received,
           tx_underrun, busy
  );
endinterface

// File: rtl/flex_counter.sv
// flex_counter: up-counter with synchronous clear and programmable wrap.
//   clk, rst      - clock, async active-high reset (count -> 0)
//   clear         - synchronous clear, wins over count_enable
//   count_enable  - advance by one; wraps to 0 after reaching rollover_val
//   rollover_val  - last count value before wrap
//   count_out     - current count
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_out = count_q;
endmodule

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: parallel-load, shift-left register feeding SDA MSB first.
//   clk, rst  - clock, async active-high reset (contents -> 0)
//   clear     - synchronous clear (highest priority)
//   load_en   - capture par_in
//   shift_en  - shift left one place, zero fill
//   par_in    - byte from the TX FIFO head
//   msb_o     - MSB of the value the register takes at the next edge
module tx_shift_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic                  msb_o
);
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear)         data_d = '0;
    else if (load_en)  data_d = par_in;
    else if (shift_en) data_d = {data_q[DATA_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  // Next-value MSB so the SDA flop can update in the same clock as the
  // load/shift instead of one clock later.
  assign msb_o = data_d[DATA_WIDTH-1];
endmodule

// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer: slave-transmit controller of the I2C target.
// Pulls bytes from the TX FIFO, drives one bit per SCL low phase (MSB first),
// releases SDA for the master's acknowledge, samples ACK/NACK and either
// fetches the next byte (ACK) or goes idle (NACK).
//   clk, rst - clock, async active-high reset
//   bus      - i2c_tx_sequencer_if.slave:
//              in : scl_rise, scl_fall, start_det, stop_det, sda_in,
//                   tx_enable, tx_data, tx_data_valid
//              out: tx_data_ack, sda_out, byte_sent, ack_received,
//                   nack_received, tx_underrun, busy (all registered)
module i2c_tx_sequencer
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  i2c_tx_sequencer_if.slave   bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t state_q, state_d;

  logic sda_q,   sda_d;
  logic pop_q,   pop_d;
  logic sent_q,  sent_d;
  logic ack_q,   ack_d;
  logic nack_q,  nack_d;
  logic under_q, under_d;
  logic busy_q,  busy_d;
  logic ackf_q,  ackf_d;

  logic             rise, fall, abort;
  logic             sr_clear, sr_load, sr_shift, sr_msb;
  logic             cnt_clear, cnt_en;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  // A simultaneous rise+fall cannot come from a sane edge detector; treat it
  // as a rise so the bit in flight is never skipped.
  assign rise     = bus.scl_rise;
  assign fall     = bus.scl_fall & ~bus.scl_rise;
  assign abort    = (state_q != ST_IDLE) &&
                    (bus.start_det || bus.stop_det || !bus.tx_enable);
  assign last_bit = (bit_cnt == LAST_BIT);

  tx_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (sr_clear),
    .load_en  (sr_load),
    .shift_en (sr_shift),
    .par_in   (bus.tx_data),
    .msb_o    (sr_msb)
  );

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bitcnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (LAST_BIT),
    .count_out    (bit_cnt)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sda_q   <= 1'b1;
      pop_q   <= 1'b0;
      sent_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      under_q <= 1'b0;
      busy_q  <= 1'b0;
      ackf_q  <= NACK;
    end else begin
      state_q <= state_d;
      sda_q   <= sda_d;
      pop_q   <= pop_d;
      sent_q  <= sent_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      under_q <= under_d;
      busy_q  <= busy_d;
      ackf_q  <= ackf_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (bus.tx_enable) state_d = ST_LOAD;
        ST_LOAD:
          if (bus.tx_data_valid) state_d = ST_BIT_WAIT_RISE;
          else if (rise)         state_d = ST_IDLE;   // no clock stretching
        ST_BIT_WAIT_RISE:
          if (rise) state_d = ST_BIT_WAIT_FALL;
        ST_BIT_WAIT_FALL:
          if (fall) state_d = last_bit ? ST_ACK_WAIT_RISE : ST_BIT_WAIT_RISE;
        ST_ACK_WAIT_RISE:
          if (rise) state_d = ST_ACK_WAIT_FALL;
        ST_ACK_WAIT_FALL:
          if (fall) state_d = (ackf_q == ACK) ? ST_LOAD : ST_IDLE;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and datapath controls.
  always_comb begin
    sda_d     = sda_q;
    pop_d     = 1'b0;
    sent_d    = 1'b0;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    under_d   = 1'b0;
    ackf_d    = ackf_q;
    sr_clear  = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    busy_d    = (state_d != ST_IDLE);

    if (abort) begin
      sda_d     = 1'b1;
      sr_clear  = 1'b1;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:
          sda_d = 1'b1;
        ST_LOAD:
          if (bus.tx_data_valid) begin
            sr_load   = 1'b1;
            cnt_clear = 1'b1;
            pop_d     = 1'b1;
            sda_d     = sr_msb;
          end else begin
            sda_d = 1'b1;
            if (rise) under_d = 1'b1;
          end
        ST_BIT_WAIT_FALL:
          if (fall) begin
            if (last_bit) begin
              sda_d  = 1'b1;       // release for the master's ACK slot
              sent_d = 1'b1;
            end else begin
              sr_shift = 1'b1;
              cnt_en   = 1'b1;
              sda_d    = sr_msb;
            end
          end
        ST_ACK_WAIT_RISE: begin
          sda_d = 1'b1;
          if (rise) begin
            ackf_d = bus.sda_in;
            ack_d  = (bus.sda_in == ACK);
            nack_d = (bus.sda_in == NACK);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_out       = sda_q;
  assign bus.tx_data_ack   = pop_q;
  assign bus.byte_sent     = sent_q;
  assign bus.ack_received  = ack_q;
  assign bus.nack_received = nack_q;
  assign bus.tx_underrun   = under_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// tb_i2c_tx_sequencer: randomized scoreboard bench for i2c_tx_sequencer.
// Stimulus tasks describe bus transactions byte by byte and push the events a
// slave transmitter must produce (FIFO pop, SDA level seen at each SCL rise,
// byte_sent, ACK/NACK, underrun); a monitor pops and compares them as the DUT
// presents them.
module tb_i2c_tx_sequencer;
  import i2c_pkg::*;

  localparam int DW = 8;
  localparam int EV_POP = 0, EV_SENT = 1, EV_ACK = 2, EV_NACK = 3, EV_UNDER = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int            exp_ev[$];
  logic          exp_sda[$];
  logic [DW-1:0] fifo[$];

  i2c_tx_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  i2c_tx_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO head presented to the DUT; garbage data while empty.
  task automatic upd_fifo();
    bus.tx_data_valid = (fifo.size() > 0);
    bus.tx_data       = (fifo.size() > 0) ? fifo[0] : DW'($urandom);
  endtask

  task automatic fifo_push(input logic [DW-1:0] b);
    fifo.push_back(b);
    upd_fifo();
  endtask

  always @(negedge clk) begin
    if (bus.tx_data_ack && fifo.size() > 0) begin
      void'(fifo.pop_front());
      upd_fifo();
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    logic [4:0] p;
    if (!rst) begin
      if (bus.scl_rise) begin
        if (exp_sda.size() == 0) begin
          checks++; failures++;
          $display("FAIL sda_at_rise: got rise with sda=%0b expected no rise", bus.sda_out);
        end else
          chk("sda_at_rise", 32'(bus.sda_out), 32'(exp_sda.pop_front()));
      end
      p = {bus.tx_underrun, bus.nack_received, bus.ack_received,
           bus.byte_sent, bus.tx_data_ack};
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          if (exp_ev.size() == 0) begin
            checks++; failures++;
            $display("FAIL event_order: got event %0d expected none", k);
          end else
            chk("event_order", 32'(k), 32'(exp_ev.pop_front()));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the selected edge-detector outputs after a random gap.
  task automatic pulse(input bit r, input bit f, input bit st, input bit sp);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) @(posedge clk);
    @(posedge clk); #1;
    bus.scl_rise = r; bus.scl_fall = f; bus.start_det = st; bus.stop_det = sp;
    @(posedge clk); #1;
    bus.scl_rise = 0; bus.scl_fall = 0; bus.start_det = 0; bus.stop_det = 0;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input bit ack, input bit more);
    for (int i = DW - 1; i >= 0; i--) begin
      if ($urandom_range(0, 7) == 0) pulse(0, 1, 0, 0);   // stray fall, ignored
      exp_sda.push_back(b[i]);
      pulse(1, $urandom_range(0, 5) == 0, 0, 0);        // sometimes rise+fall
      if (i == 0) exp_ev.push_back(EV_SENT);
      pulse(0, 1, 0, 0);
    end
    bus.sda_in = ack ? ACK : NACK;
    exp_sda.push_back(1'b1);
    exp_ev.push_back(ack ? EV_ACK : EV_NACK);
    pulse(1, 0, 0, 0);
    if (more) exp_ev.push_back(EV_POP);
    pulse(0, 1, 0, 0);
    bus.sda_in = 1'b1;
  endtask

  // n bytes; all ACKed and ended by STOP, or last one NACKed.
  task automatic run_txn(input int n, input logic [3:0][DW-1:0] bs, input bit stop_end);
    for (int i = 0; i < n; i++) fifo_push(bs[i]);
    exp_ev.push_back(EV_POP);
    bus.tx_enable = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < n; i++)
      send_byte(bs[i], (i < n - 1) || stop_end, i < n - 1);
    if (stop_end) pulse(0, 0, 0, 1);
    bus.tx_enable = 1'b0;
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_sda", 32'(bus.sda_out), 1);
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [DW-1:0] v;
    bus.scl_rise = 0; bus.scl_fall = 0; bus.start_det = 0; bus.stop_det = 0;
    bus.sda_in = 1; bus.tx_enable = 0;
    upd_fifo();
    #1 rst = 1'b1;
    #2;
    chk("rst_sda", 32'(bus.sda_out), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pop", 32'(bus.tx_data_ack), 0);
    chk("rst_sent", 32'(bus.byte_sent), 0);
    chk("rst_ack", 32'(bus.ack_received), 0);
    chk("rst_nack", 32'(bus.nack_received), 0);
    chk("rst_under", 32'(bus.tx_underrun), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // 0xA5, ACK, then STOP while waiting for the next byte.
    run_txn(1, {24'h0, 8'hA5}, 1'b1);
    // 0x3C ACK, 0xFF NACK.
    run_txn(2, {16'h0, 8'hFF, 8'h3C}, 1'b0);

    // Underrun: nothing in the FIFO when the master clocks.
    bus.tx_enable = 1'b1;
    wait_cyc(3);
    exp_sda.push_back(1'b1);
    exp_ev.push_back(EV_UNDER);
    pulse(1, 0, 0, 0);
    bus.tx_enable = 1'b0;
    chk("under_busy", 32'(bus.busy), 0);
    chk("under_sda", 32'(bus.sda_out), 1);

    // START after four bits of 0x0F; later SCL edges must do nothing.
    v = 8'h0F;
    fifo_push(v);
    exp_ev.push_back(EV_POP);
    bus.tx_enable = 1'b1;
    wait_cyc(3);
    for (int i = DW - 1; i >= DW - 4; i--) begin
      exp_sda.push_back(v[i]);
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
    end
    pulse(0, 0, 1, 0);
    bus.tx_enable = 1'b0;
    chk("start_busy", 32'(bus.busy), 0);
    chk("start_sda", 32'(bus.sda_out), 1);
    repeat (3) begin
      exp_sda.push_back(1'b1);
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
    end
    chk("start_idle_busy", 32'(bus.busy), 0);

    // Reset in the middle of 0x81, then a clean resend.
    v = 8'h81;
    fifo_push(v);
    exp_ev.push_back(EV_POP);
    bus.tx_enable = 1'b1;
    wait_cyc(3);
    for (int i = DW - 1; i >= DW - 3; i--) begin
      exp_sda.push_back(v[i]);
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
    end
    exp_sda.push_back(v[DW-4]);
    pulse(1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sda", 32'(bus.sda_out), 1);
    chk("midrst_busy", 32'(bus.busy), 0);
    bus.tx_enable = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    run_txn(1, {24'h0, 8'h81}, 1'b0);

    // Random transactions.
    for (int t = 0; t < 20; t++)
      run_txn($urandom_range(1, 3), {$urandom}, 1'($urandom_range(0, 1)));

    wait_cyc(4);
    chk("sda_queue_drained", 32'(exp_sda.size()), 0);
    chk("event_queue_drained", 32'(exp_ev.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
